sysid_boot_checker: RTL and testbench

- Avalon-MM master that sits directly upstream of the system-ID slave and consumes its readdata.
- After reset, or on request, it reads the ID word (address 0) and the timestamp word (address 1).
- It compares both against build-time expected values and publishes sticky pass/fail flags.
- Firmware and the board status LEDs use these flags to detect a bitstream/software mismatch before the synthesizer audio path is enabled.

---
 rtl/sysid_pkg.sv | 20 ++
 rtl/sysid_boot_checker.sv | 142 ++++++++++++++
 tb/tb_sysid_boot_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM states, sysid word
// addresses and the expected values regenerated alongside the sysid slave.
package sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Regenerate together with the sysid slave so the check tracks the build.
    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1427154916;
    localparam logic [15:0] SYSID_DEFAULT_TIMEOUT   = 16'd255;

endpackage

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words once after reset
// (or on start) and publishes sticky pass/fail flags for firmware and LEDs.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter logic [15:0] TIMEOUT_CYCLES     = SYSID_DEFAULT_TIMEOUT,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output state_t      dbg_state
);

    // Handshake: a read is accepted in the cycle where avm_read=1 and
    // avm_waitrequest=0; avm_readdata is valid in that same cycle (no latency).

    state_t      state_q;
    logic        auto_pending_q;
    logic [15:0] wait_cnt_q;
    logic        read_q;
    logic        address_q;
    logic        busy_q;
    logic        done_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        timeout_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;

    logic        launch;
    logic [15:0] wait_cnt_next;
    logic        timeout_hit;

    // auto_pending is only ever set while in IDLE, so DONE relaunches on start alone.
    assign launch        = ((state_q == IDLE) && (start || auto_pending_q)) ||
                           ((state_q == DONE) && start);
    assign wait_cnt_next = wait_cnt_q + 16'd1;
    assign timeout_hit   = (wait_cnt_next == TIMEOUT_CYCLES);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            auto_pending_q <= AUTO_START;
            wait_cnt_q     <= '0;
            read_q         <= 1'b0;
            address_q      <= SYSID_ADDR_ID;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            id_ok_q        <= 1'b0;
            ts_ok_q        <= 1'b0;
            timeout_q      <= 1'b0;
            id_value_q     <= '0;
            ts_value_q     <= '0;
        end else if (launch) begin
            state_q        <= RD_ID;
            auto_pending_q <= 1'b0;
            wait_cnt_q     <= '0;
            read_q         <= 1'b1;
            address_q      <= SYSID_ADDR_ID;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            id_ok_q        <= 1'b0;
            ts_ok_q        <= 1'b0;
            timeout_q      <= 1'b0;
            id_value_q     <= '0;
            ts_value_q     <= '0;
        end else begin
            unique case (state_q)
                RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value_q <= avm_readdata;
                        id_ok_q    <= (avm_readdata == EXPECTED_ID);
                        wait_cnt_q <= '0;
                        address_q  <= SYSID_ADDR_TS;
                        state_q    <= RD_TS;
                    end else if (timeout_hit) begin
                        timeout_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        read_q     <= 1'b0;
                        address_q  <= SYSID_ADDR_ID;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_next;
                    end
                end
                RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value_q <= avm_readdata;
                        ts_ok_q    <= (avm_readdata == EXPECTED_TIMESTAMP);
                        wait_cnt_q <= '0;
                        read_q     <= 1'b0;
                        address_q  <= SYSID_ADDR_ID;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else if (timeout_hit) begin
                        timeout_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        read_q     <= 1'b0;
                        address_q  <= SYSID_ADDR_ID;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign avm_read    = read_q;
    assign avm_address = address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign match       = done_q & id_ok_q & ts_ok_q & ~timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: one checker with AUTO_START=1 and default timeout, one with
// AUTO_START=0 and TIMEOUT_CYCLES=4, each fed by a zero-latency sysid model.
module tb_sysid_boot_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1427154916;

  logic clk;
  int   passes = 0;
  int   fails  = 0;
  int   checks = 0;

  // instance a: AUTO_START=1, TIMEOUT_CYCLES=255
  logic        a_rst_n, a_start, a_addr, a_read, a_wr;
  logic [31:0] a_rdata, a_id_word, a_ts_word, a_id_value, a_ts_value;
  logic        a_busy, a_done, a_id_ok, a_ts_ok, a_match, a_timeout;
  state_t      a_state;

  // instance b: AUTO_START=0, TIMEOUT_CYCLES=4
  logic        b_rst_n, b_start, b_addr, b_read, b_wr;
  logic [31:0] b_rdata, b_id_word, b_ts_word, b_id_value, b_ts_value;
  logic        b_busy, b_done, b_id_ok, b_ts_ok, b_match, b_timeout;
  state_t      b_state;

  assign a_rdata = (a_addr == 1'b1) ? a_ts_word : a_id_word;
  assign b_rdata = (b_addr == 1'b1) ? b_ts_word : b_id_word;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(16'd255), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clk), .reset_n(a_rst_n), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wr),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .id_ok(a_id_ok),
    .ts_ok(a_ts_ok), .match(a_match), .timeout(a_timeout),
    .id_value(a_id_value), .ts_value(a_ts_value), .dbg_state(a_state)
  );

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(16'd4), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset_n(b_rst_n), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .id_ok(b_id_ok),
    .ts_ok(b_ts_ok), .match(b_match), .timeout(b_timeout),
    .id_value(b_id_value), .ts_value(b_ts_value), .dbg_state(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_wr = 1'b0;
    a_id_word = 32'd0; a_ts_word = EXP_TS;
    b_rst_n = 1'b0; b_start = 1'b0; b_wr = 1'b0;
    b_id_word = 32'd0; b_ts_word = EXP_TS;
    step(); step();

    // reset state
    chk("rst_read",    {31'd0, a_read},    32'd0);
    chk("rst_addr",    {31'd0, a_addr},    32'd0);
    chk("rst_busy",    {31'd0, a_busy},    32'd0);
    chk("rst_done",    {31'd0, a_done},    32'd0);
    chk("rst_id_ok",   {31'd0, a_id_ok},   32'd0);
    chk("rst_ts_ok",   {31'd0, a_ts_ok},   32'd0);
    chk("rst_match",   {31'd0, a_match},   32'd0);
    chk("rst_timeout", {31'd0, a_timeout}, 32'd0);
    chk("rst_id_val",  a_id_value,         32'd0);
    chk("rst_ts_val",  a_ts_value,         32'd0);
    chk("rst_state",   32'(a_state),       32'(IDLE));

    // auto check after reset release
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();
    chk("auto_rd1_read", {31'd0, a_read}, 32'd1);
    chk("auto_rd1_addr", {31'd0, a_addr}, 32'd0);
    chk("auto_rd1_busy", {31'd0, a_busy}, 32'd1);
    chk("b_noauto_read", {31'd0, b_read}, 32'd0);
    step();
    chk("auto_rd2_read", {31'd0, a_read}, 32'd1);
    chk("auto_rd2_addr", {31'd0, a_addr}, 32'd1);
    chk("auto_rd2_done", {31'd0, a_done}, 32'd0);
    step();
    chk("auto_end_read",  {31'd0, a_read},  32'd0);
    chk("auto_end_busy",  {31'd0, a_busy},  32'd0);
    chk("auto_done",      {31'd0, a_done},  32'd1);
    chk("auto_match",     {31'd0, a_match}, 32'd1);
    chk("auto_id_value",  a_id_value,       32'd0);
    chk("auto_ts_value",  a_ts_value,       32'd1427154916);
    step();
    chk("auto_read_idle", {31'd0, a_read},  32'd0);
    chk("auto_state",     32'(a_state),     32'(DONE));
    chk("b_idle_state",   32'(b_state),     32'(IDLE));

    // timestamp mismatch only
    a_ts_word = 32'd1427154917;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("ts_bad_restart_done", {31'd0, a_done}, 32'd0);
    chk("ts_bad_restart_read", {31'd0, a_read}, 32'd1);
    step(); step();
    chk("ts_bad_done",    {31'd0, a_done},    32'd1);
    chk("ts_bad_id_ok",   {31'd0, a_id_ok},   32'd1);
    chk("ts_bad_ts_ok",   {31'd0, a_ts_ok},   32'd0);
    chk("ts_bad_match",   {31'd0, a_match},   32'd0);
    chk("ts_bad_timeout", {31'd0, a_timeout}, 32'd0);
    chk("ts_bad_value",   a_ts_value,         32'd1427154917);

    // waitrequest held 3 cycles on each read
    a_ts_word = EXP_TS;
    a_wr = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    chk("stall_id_read", {31'd0, a_read}, 32'd1);
    chk("stall_id_busy", {31'd0, a_busy}, 32'd1);
    step(); step();
    a_wr = 1'b0;
    step();
    a_wr = 1'b1;
    chk("stall_ts_addr",  {31'd0, a_addr}, 32'd1);
    chk("stall_id_value", a_id_value,      32'd0);
    chk("stall_id_ok",    {31'd0, a_id_ok}, 32'd1);
    step(); step(); step();
    a_wr = 1'b0;
    chk("stall_n8_done", {31'd0, a_done}, 32'd0);
    chk("stall_n8_busy", {31'd0, a_busy}, 32'd1);
    step();
    chk("stall_n9_done",  {31'd0, a_done},    32'd1);
    chk("stall_match",    {31'd0, a_match},   32'd1);
    chk("stall_ts_value", a_ts_value,         EXP_TS);
    chk("stall_timeout",  {31'd0, a_timeout}, 32'd0);

    // timeout on instance b: waitrequest stuck high, TIMEOUT_CYCLES=4
    b_wr = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step(); step(); step();
    chk("to_pre_read",    {31'd0, b_read},    32'd1);
    chk("to_pre_timeout", {31'd0, b_timeout}, 32'd0);
    step();
    chk("to_timeout", {31'd0, b_timeout}, 32'd1);
    chk("to_read",    {31'd0, b_read},    32'd0);
    chk("to_done",    {31'd0, b_done},    32'd1);
    chk("to_match",   {31'd0, b_match},   32'd0);
    chk("to_id_ok",   {31'd0, b_id_ok},   32'd0);

    // start while busy ignored, start in DONE restarts
    a_start = 1'b1;
    step();
    chk("busy_start_state", 32'(a_state), 32'(RD_ID));
    step();
    a_start = 1'b0;
    chk("busy_start_ignored", 32'(a_state), 32'(RD_TS));
    step();
    chk("busy_start_done", {31'd0, a_done}, 32'd1);
    step();
    chk("busy_start_no_requeue", {31'd0, a_read}, 32'd0);
    chk("busy_start_state_done", 32'(a_state),    32'(DONE));
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("restart_done_clr",  {31'd0, a_done},  32'd0);
    chk("restart_ts_ok_clr", {31'd0, a_ts_ok}, 32'd0);
    chk("restart_ts_val_clr", a_ts_value,      32'd0);
    chk("restart_read",      {31'd0, a_read},  32'd1);
    step(); step();
    chk("restart_done",  {31'd0, a_done},  32'd1);
    chk("restart_match", {31'd0, a_match}, 32'd1);

    // reset mid-read on instance b (AUTO_START=0)
    b_wr = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step();
    chk("mid_state", 32'(b_state),   32'(RD_TS));
    chk("mid_read",  {31'd0, b_read}, 32'd1);
    b_rst_n = 1'b0;
    #1;
    chk("async_read",    {31'd0, b_read},    32'd0);
    chk("async_busy",    {31'd0, b_busy},    32'd0);
    chk("async_done",    {31'd0, b_done},    32'd0);
    chk("async_timeout", {31'd0, b_timeout}, 32'd0);
    step();
    b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_read", {31'd0, b_read}, 32'd0);
      chk("post_rst_idle",    32'(b_state),    32'(IDLE));
    end
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("post_rst_start_read", {31'd0, b_read}, 32'd1);
    step(); step();
    chk("post_rst_done",  {31'd0, b_done},  32'd1);
    chk("post_rst_match", {31'd0, b_match}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
